note_sequence_player: RTL



---
 rtl/note_sequence_player.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/note_sequence_player.sv
// Memory-game challenge player: latches a packed level on start, plays each note then a gap, pulses done.
// Optional macro PLAYER_TEMPO_EN adds a latched tempo input that shortens the note on-time.
module note_sequence_player #(
  parameter int NOTE_W      = 4,
  parameter int MAX_NOTES   = 8,
  parameter int LEN_W       = 4,
  parameter int NOTE_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 5000000,
  parameter int CNT_W       = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
`ifdef PLAYER_TEMPO_EN
  input  logic [1:0]                  tempo,
`endif
  input  logic [NOTE_W*MAX_NOTES-1:0] level_data,
  input  logic [LEN_W-1:0]            level_length,
  output logic [NOTE_W-1:0]           note_out,
  output logic [LEN_W-1:0]            note_index,
  output logic                        busy,
  output logic                        done
);

  localparam int                DATA_W   = NOTE_W * MAX_NOTES;
  localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(MAX_NOTES);
  localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_NOTE   = 2'd1,
    S_GAP    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    timer_r, timer_s;
  logic [LEN_W-1:0]    idx_r, idx_s;
  logic [LEN_W-1:0]    len_r, len_s;
  logic [DATA_W-1:0]   data_r, data_s;
  logic [NOTE_W-1:0]   note_r, note_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic [LEN_W-1:0]    len_in_s;
  logic [CNT_W-1:0]    start_load_s;
  logic [CNT_W-1:0]    run_load_s;

  // Slot 0 sits in the most-significant NOTE_W bits of the packed level.
  function automatic logic [NOTE_W-1:0] slot_of(input logic [DATA_W-1:0] d,
                                                input logic [LEN_W-1:0]  idx);
    logic [NOTE_W-1:0] s;
    s = {NOTE_W{1'b0}};
    for (int i = 0; i < MAX_NOTES; i++) begin
      if (idx == LEN_W'(i)) begin
        s = d[(MAX_NOTES-1-i)*NOTE_W +: NOTE_W];
      end
    end
    return s;
  endfunction

`ifdef PLAYER_TEMPO_EN
  logic [1:0] tempo_r;

  // On-time halves per tempo step but never drops below one cycle.
  function automatic logic [CNT_W-1:0] on_load(input logic [1:0] t);
    logic [CNT_W-1:0] on;
    on = CNT_W'(NOTE_CYCLES) >> t;
    if (on == {CNT_W{1'b0}}) begin
      on = CNT_W'(1);
    end
    return on - CNT_W'(1);
  endfunction

  assign start_load_s = on_load(tempo);
  assign run_load_s   = on_load(tempo_r);

  // Tempo is captured together with the level so it holds for the whole playback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tempo_r <= 2'd0;
    end else if (state_r == S_IDLE && start && !abort) begin
      tempo_r <= tempo;
    end else begin
      tempo_r <= tempo_r;
    end
  end
`else
  assign start_load_s = CNT_W'(NOTE_CYCLES - 1);
  assign run_load_s   = CNT_W'(NOTE_CYCLES - 1);
`endif

  assign len_in_s = (level_length > MAX_LEN) ? MAX_LEN : level_length;

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    idx_s   = idx_r;
    len_s   = len_r;
    data_s  = data_r;
    note_s  = note_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        note_s = {NOTE_W{1'b0}};
        busy_s = 1'b0;
        if (abort) begin
          state_s = S_IDLE;
        end else if (start) begin
          data_s = level_data;
          len_s  = len_in_s;
          idx_s  = {LEN_W{1'b0}};
          if (len_in_s == {LEN_W{1'b0}}) begin
            state_s = S_FINISH;
            done_s  = 1'b1;
          end else begin
            state_s = S_NOTE;
            timer_s = start_load_s;
            note_s  = slot_of(level_data, {LEN_W{1'b0}});
            busy_s  = 1'b1;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_NOTE: begin
        if (abort) begin
          state_s = S_IDLE;
          note_s  = {NOTE_W{1'b0}};
          busy_s  = 1'b0;
        end else if (timer_r == {CNT_W{1'b0}}) begin
          state_s = S_GAP;
          timer_s = GAP_LOAD;
          note_s  = {NOTE_W{1'b0}};
        end else begin
          timer_s = timer_r - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (abort) begin
          state_s = S_IDLE;
          note_s  = {NOTE_W{1'b0}};
          busy_s  = 1'b0;
        end else if (timer_r == {CNT_W{1'b0}}) begin
          if (idx_r == len_r - LEN_W'(1)) begin
            state_s = S_FINISH;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            state_s = S_NOTE;
            idx_s   = idx_r + LEN_W'(1);
            note_s  = slot_of(data_r, idx_r + LEN_W'(1));
            timer_s = run_load_s;
          end
        end else begin
          timer_s = timer_r - CNT_W'(1);
        end
      end
      S_FINISH: begin
        state_s = S_IDLE;
        note_s  = {NOTE_W{1'b0}};
        busy_s  = 1'b0;
      end
      default: begin
        state_s = S_IDLE;
        note_s  = {NOTE_W{1'b0}};
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, timer, latched level and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      timer_r <= {CNT_W{1'b0}};
      idx_r   <= {LEN_W{1'b0}};
      len_r   <= {LEN_W{1'b0}};
      data_r  <= {DATA_W{1'b0}};
      note_r  <= {NOTE_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
      idx_r   <= idx_s;
      len_r   <= len_s;
      data_r  <= data_s;
      note_r  <= note_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign note_out   = note_r;
  assign note_index = idx_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule
